// File: rtl/jtopl_busq.sv
// CPU-side write front end for OPL/OPL3: per-bank address latches, a data-write
// FIFO and a paced issuer that forwards queued writes to the register decoder.
module jtopl_busq #(
    parameter int BANKS     = 1,
    parameter int DEPTH     = 4,
    parameter int DATA_WAIT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cenop,
    input  logic [7:0] din,
    input  logic [1:0] addr,
    input  logic       write,
    output logic       busy,
    output logic       overrun,
    output logic       new_mode,
    output logic       reg_wr,
    output logic       reg_bank,
    output logic [7:0] reg_sel,
    output logic [7:0] reg_din,
    input  logic       flag_A,
    input  logic       flag_B,
    output logic [7:0] dout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [7:0]    WAIT_INIT = 8'(DATA_WAIT);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    typedef struct packed {
        logic       bank;
        logic [7:0] sel;
        logic [7:0] data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [7:0]      sel_q [2];
    logic [7:0]      sel_d [2];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            overrun_q, overrun_d;
    logic            new_mode_q, new_mode_d;
    logic            reg_wr_q, reg_wr_d;
    logic            reg_bank_q, reg_bank_d;
    logic [7:0]      reg_sel_q, reg_sel_d;
    logic [7:0]      reg_din_q, reg_din_d;
    logic [7:0]      dout_q, dout_d;

    logic   bank_in;
    logic   full;
    logic   empty;
    logic   pop;
    logic   push_req;
    logic   push;
    entry_t head;

    assign bank_in  = (BANKS == 2) ? addr[1] : 1'b0;
    assign full     = (count_q == FULL);
    assign empty    = (count_q == '0);
    assign head     = mem_q[rd_ptr_q];
    assign pop      = (state_q == ST_IDLE) && cenop && !empty;
    assign push_req = write && addr[0];
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push     = push_req && (!full || pop);

    always_comb begin
        sel_d      = sel_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        overrun_d  = overrun_q;
        new_mode_d = new_mode_q;
        reg_wr_d   = 1'b0;
        reg_bank_d = reg_bank_q;
        reg_sel_d  = reg_sel_q;
        reg_din_d  = reg_din_q;
        dout_d     = {flag_A | flag_B, flag_A, flag_B, 5'd0};

        if (write && !addr[0]) begin
            sel_d[bank_in] = din;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (push_req && !push) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    rd_ptr_d   = rd_ptr_q + AW'(1);
                    reg_wr_d   = 1'b1;
                    reg_sel_d  = head.sel;
                    reg_din_d  = head.data;
                    reg_bank_d = head.bank;
                    // Bank-1 writes fold onto bank 0 until NEW mode is enabled.
                    if (BANKS == 2 && head.bank) begin
                        if (head.sel == 8'h05) begin
                            new_mode_d = head.data[0];
                        end else if (!new_mode_q) begin
                            reg_bank_d = 1'b0;
                        end
                    end
                    if (DATA_WAIT != 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cenop) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{bank: bank_in, sel: sel_q[bank_in], data: din};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q[0]   <= 8'd0;
            sel_q[1]   <= 8'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            overrun_q  <= 1'b0;
            new_mode_q <= 1'b0;
            reg_wr_q   <= 1'b0;
            reg_bank_q <= 1'b0;
            reg_sel_q  <= 8'd0;
            reg_din_q  <= 8'd0;
            dout_q     <= 8'd0;
        end else begin
            sel_q      <= sel_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            overrun_q  <= overrun_d;
            new_mode_q <= new_mode_d;
            reg_wr_q   <= reg_wr_d;
            reg_bank_q <= reg_bank_d;
            reg_sel_q  <= reg_sel_d;
            reg_din_q  <= reg_din_d;
            dout_q     <= dout_d;
        end
    end

    assign busy     = full;
    assign overrun  = overrun_q;
    assign new_mode = new_mode_q;
    assign reg_wr   = reg_wr_q;
    assign reg_bank = reg_bank_q;
    assign reg_sel  = reg_sel_q;
    assign reg_din  = reg_din_q;
    assign dout     = dout_q;

endmodule

// File: tb/tb_jtopl_busq.sv
// Bench for jtopl_busq: a cycle-level queue model tracks every output each
// cycle, alongside directed sequences and a status-byte vector table.
module tb_jtopl_busq;

    localparam int BANKS     = 2;
    localparam int DEPTH     = 4;
    localparam int DATA_WAIT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cenop = 1'b0;
    logic [7:0] din = 8'd0;
    logic [1:0] addr = 2'd0;
    logic       write = 1'b0;
    logic       flag_A = 1'b0;
    logic       flag_B = 1'b0;
    logic       busy, overrun, new_mode, reg_wr, reg_bank;
    logic [7:0] reg_sel, reg_din, dout;

    jtopl_busq #(.BANKS(BANKS), .DEPTH(DEPTH), .DATA_WAIT(DATA_WAIT)) dut (
        .clk(clk), .rst(rst), .cenop(cenop), .din(din), .addr(addr), .write(write),
        .busy(busy), .overrun(overrun), .new_mode(new_mode), .reg_wr(reg_wr),
        .reg_bank(reg_bank), .reg_sel(reg_sel), .reg_din(reg_din),
        .flag_A(flag_A), .flag_B(flag_B), .dout(dout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // cenop source: 0 = off, 1 = every 4 clk, 2 = random
    int cen_mode = 0;
    int phase_cnt = 0;
    always @(posedge clk) begin
        #1;
        case (cen_mode)
            1:       cenop = (phase_cnt % 4 == 0);
            2:       cenop = ($urandom_range(2) == 0);
            default: cenop = 1'b0;
        endcase
        phase_cnt++;
    end

    // Reference model: the FIFO is a queue, the issuer a count of cenops still to skip.
    typedef struct packed {
        logic       bank;
        logic [7:0] sel;
        logic [7:0] data;
    } entry_t;

    entry_t     mq[$];
    logic [7:0] m_sel [2];
    logic       m_new, m_wr, m_bank, m_over;
    logic [7:0] m_rsel, m_rdin, m_dout;
    int         m_ticks;
    logic       m_bnk;
    bit         m_pop, m_full;
    entry_t     m_head;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_sel[0] = 8'd0; m_sel[1] = 8'd0;
            m_new = 1'b0; m_wr = 1'b0; m_bank = 1'b0; m_over = 1'b0;
            m_rsel = 8'd0; m_rdin = 8'd0; m_dout = 8'd0;
            m_ticks = 0;
        end else begin
            m_bnk  = (BANKS == 2) ? addr[1] : 1'b0;
            m_full = (mq.size() == DEPTH);
            m_pop  = (m_ticks == 0) && cenop && (mq.size() != 0);
            m_wr   = m_pop;
            if (m_pop) begin
                m_head = mq.pop_front();
                m_rsel = m_head.sel;
                m_rdin = m_head.data;
                if (m_head.bank && m_head.sel == 8'h05) begin
                    m_new  = m_head.data[0];
                    m_bank = 1'b1;
                end else if (m_head.bank && !m_new) begin
                    m_bank = 1'b0;
                end else begin
                    m_bank = m_head.bank;
                end
                m_ticks = DATA_WAIT;
            end else if (cenop && m_ticks > 0) begin
                m_ticks--;
            end
            if (write && addr[0]) begin
                if (!m_full || m_pop) mq.push_back('{m_bnk, m_sel[m_bnk], din});
                else m_over = 1'b1;
            end
            if (write && !addr[0]) m_sel[m_bnk] = din;
            m_dout = {flag_A | flag_B, flag_A, flag_B, 5'd0};
        end
    end

    // Per-cycle comparison against the model, plus strobe bookkeeping for directed tests.
    int         cen_ticks = 0;
    int         wr_count = 0;
    int         wr_ticks[$];
    logic [7:0] wr_data[$];
    logic       last_bank;
    logic [7:0] last_sel, last_din;

    always @(posedge clk) if (cenop) cen_ticks++;

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("reg_wr",   32'(reg_wr),   32'(m_wr));
            checkOutput("reg_bank", 32'(reg_bank), 32'(m_bank));
            checkOutput("reg_sel",  32'(reg_sel),  32'(m_rsel));
            checkOutput("reg_din",  32'(reg_din),  32'(m_rdin));
            checkOutput("new_mode", 32'(new_mode), 32'(m_new));
            checkOutput("overrun",  32'(overrun),  32'(m_over));
            checkOutput("busy",     32'(busy),     32'(mq.size() == DEPTH));
            checkOutput("dout",     32'(dout),     32'(m_dout));
        end
        if (reg_wr === 1'b1) begin
            wr_count++;
            wr_ticks.push_back(cen_ticks);
            wr_data.push_back(reg_din);
            last_bank = reg_bank;
            last_sel  = reg_sel;
            last_din  = reg_din;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [1:0] a, input logic [7:0] d);
        write = w;
        addr  = a;
        din   = d;
        @(posedge clk);
        #2;
        write = 1'b0;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic waitWrites(input int n, input int budget, input string name);
        for (int i = 0; i < budget && wr_count < n; i++) idle(1);
        checkOutput(name, 32'(wr_count), 32'(n));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_reg_wr"},   32'(reg_wr),   32'(0));
        checkOutput({tag, "_busy"},     32'(busy),     32'(0));
        checkOutput({tag, "_overrun"},  32'(overrun),  32'(0));
        checkOutput({tag, "_new_mode"}, 32'(new_mode), 32'(0));
        checkOutput({tag, "_reg_bank"}, 32'(reg_bank), 32'(0));
        checkOutput({tag, "_reg_sel"},  32'(reg_sel),  32'(0));
        checkOutput({tag, "_reg_din"},  32'(reg_din),  32'(0));
        checkOutput({tag, "_dout"},     32'(dout),     32'(0));
    endtask

    typedef struct {
        logic       fa;
        logic       fb;
        logic [7:0] exp_dout;
    } flag_vec_t;

    flag_vec_t tbl [4];
    bit        found;
    int        r;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 8'hC0};
        tbl[1] = '{1'b0, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 1'b1, 8'hA0};
        tbl[3] = '{1'b1, 1'b1, 8'hE0};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        check_en = 1'b1;
        checkResetValues("reset");

        // Single address + data write to bank 0
        cen_mode = 1;
        wr_count = 0;
        applyStimulus(1'b1, 2'b00, 8'h20);
        applyStimulus(1'b1, 2'b01, 8'h31);
        waitWrites(1, 40, "single_issue");
        idle(30);
        checkOutput("single_count", 32'(wr_count), 32'(1));
        checkOutput("single_bank",  32'(last_bank), 32'(0));
        checkOutput("single_sel",   32'(last_sel),  32'(8'h20));
        checkOutput("single_din",   32'(last_din),  32'(8'h31));

        // Six back-to-back data writes into a stalled FIFO
        cen_mode = 0;
        resetDut();
        applyStimulus(1'b1, 2'b00, 8'h40);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 2'b01, 8'(8'h10 + i));
            if (i == 3) begin
                checkOutput("six_busy4",    32'(busy),    32'(1));
                checkOutput("six_overrun4", 32'(overrun), 32'(0));
            end
            if (i == 4) checkOutput("six_overrun5", 32'(overrun), 32'(1));
        end
        wr_count = 0;
        wr_ticks.delete();
        wr_data.delete();
        cen_mode = 1;
        waitWrites(4, 120, "six_issues");
        idle(40);
        checkOutput("six_count", 32'(wr_count), 32'(4));
        for (int i = 1; i < wr_ticks.size(); i++)
            checkOutput("six_spacing", 32'(wr_ticks[i] - wr_ticks[i-1]), 32'(DATA_WAIT + 1));
        for (int i = 0; i < wr_data.size(); i++)
            checkOutput("six_order", 32'(wr_data[i]), 32'(8'h10 + i));

        // Push on the same cycle as a pop with the FIFO full
        cen_mode = 0;
        resetDut();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b01, 8'(8'h50 + i));
        checkOutput("pp_full", 32'(busy), 32'(1));
        cen_mode = 1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            idle(1);
            if (cenop) found = 1'b1;
        end
        checkOutput("pp_cen_wait", 32'(found), 32'(1));
        applyStimulus(1'b1, 2'b01, 8'h5F);
        checkOutput("pp_busy",    32'(busy),    32'(1));
        checkOutput("pp_overrun", 32'(overrun), 32'(0));
        checkOutput("pp_reg_wr",  32'(reg_wr),  32'(1));
        idle(40);

        // Dual-bank mapping and the NEW-mode gate
        resetDut();
        wr_count = 0;
        applyStimulus(1'b1, 2'b10, 8'hB0);
        applyStimulus(1'b1, 2'b11, 8'h2A);
        waitWrites(1, 40, "bank_first");
        checkOutput("bank_fold",   32'(last_bank), 32'(0));
        checkOutput("bank_sel",    32'(last_sel),  32'(8'hB0));
        checkOutput("bank_new0",   32'(new_mode),  32'(0));
        applyStimulus(1'b1, 2'b10, 8'h05);
        applyStimulus(1'b1, 2'b11, 8'h01);
        applyStimulus(1'b1, 2'b10, 8'hB0);
        applyStimulus(1'b1, 2'b11, 8'h2A);
        waitWrites(3, 80, "bank_second");
        checkOutput("bank_new1",   32'(new_mode),  32'(1));
        checkOutput("bank_keep",   32'(last_bank), 32'(1));
        checkOutput("bank_sel2",   32'(last_sel),  32'(8'hB0));
        checkOutput("bank_din2",   32'(last_din),  32'(8'h2A));

        // Reset while entries are queued and the issuer is waiting
        cen_mode = 0;
        resetDut();
        applyStimulus(1'b1, 2'b00, 8'h60);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b01, 8'(8'h70 + i));
        wr_count = 0;
        cen_mode = 1;
        waitWrites(1, 20, "mid_first");
        idle(1);
        rst = 1'b1;
        @(posedge clk);
        #2;
        checkResetValues("mid_reset");
        rst = 1'b0;
        wr_count = 0;
        idle(60);
        checkOutput("mid_no_issue", 32'(wr_count), 32'(0));

        // Status byte vectors
        for (int i = 0; i < 4; i++) begin
            flag_A = tbl[i].fa;
            flag_B = tbl[i].fb;
            @(posedge clk);
            #2;
            checkOutput("dout_vec", 32'(dout), 32'(tbl[i].exp_dout));
        end
        flag_A = 1'b0;
        flag_B = 1'b0;

        // Randomised traffic against the model
        cen_mode = 2;
        for (int c = 0; c < 1500; c++) begin
            flag_A = 1'($urandom_range(1));
            flag_B = 1'($urandom_range(1));
            r = int'($urandom_range(9));
            if (c % 400 == 399) begin
                resetDut();
            end else if (r < 3) begin
                applyStimulus(1'b1, {1'($urandom_range(1)), 1'b0},
                              ($urandom_range(3) == 0) ? 8'h05 : 8'($urandom_range(255)));
            end else if (r < 6) begin
                applyStimulus(1'b1, {1'($urandom_range(1)), 1'b1}, 8'($urandom_range(255)));
            end else begin
                idle(1);
            end
        end
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
